barrel_shifter_right_pipe: RTL and testbench
============================================

Name: barrel_shifter_right_pipe

Overview:
- 64-bit right barrel shifter, the complement of the existing combinational left shifter in the MDCLCG datapath.
- Supports logical (zero-fill) and arithmetic (sign-fill) modes, and reports a sticky OR of all bits shifted out.
- Three-stage registered pipeline with valid/ready handshaking on both sides, so it can sit between the LCG multiply/add stages and downstream consumers under backpressure.

Parameters:
- WIDTH, 64, data width; fixed at 64 for this revision.
- SHW, 6, shift-amount width (log2 WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  shifter can accept a beat this cycle.
- in_data  input  64  operand.
- shift  input  6  right-shift amount, 0..63.
- arith  input  1  1 = sign-fill from in_data[63]; 0 = zero-fill.
- out_valid  output  1  out_data/out_sticky valid.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  64  shifted result.
- out_sticky  output  1  OR of all bits shifted out of in_data.
- busy  output  1  any pipeline stage holds a valid beat.

Behaviour:
- Reset: asynchronous on rst_n low; all stage valids 0, all data/shift/mode/sticky registers 0.
  - Outputs during and after reset: out_valid=0, out_data=0, out_sticky=0, busy=0, in_ready=1.
- Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Stage 1 captures in_data >> shift[1:0], plus the fill bit, shift[5:2], arith, and sticky.
- Stage 2 applies shift[3:2] (0/4/8/12) and ORs newly dropped bits into sticky.
- Stage 3 applies shift[5:4] (0/16/32/48) and updates sticky; its registers drive out_*.
- Fill bit = arith & in_data[63], latched in stage 1 and carried forward.
- Sticky at each stage = previous sticky | OR of the bits discarded by that stage.
- Latency: a beat accepted in cycle N appears with out_valid=1 at cycle N+3, provided no stall.
- Throughput: one beat per cycle while out_ready=1.
- Stage k advances when its successor is empty or the successor is advancing. Stage 3 "advances" when out_ready=1 or it is empty.
- in_ready = ~v1 | stage-1 advancing. This is combinational from out_ready through the stage-valid chain; there is no skid buffer.
- Bubbles collapse: an empty stage accepts from its predecessor even when later stages are stalled.
- Capacity: 3 beats. With out_ready=0 and all stages full, in_ready=0.
- Stalled stages hold data, shift remainder, fill and sticky unchanged. out_data is stable while out_valid && !out_ready.
- Ordering: strictly FIFO; no reordering or dropping.
- Boundary values:
  - shift=0 passes in_data unchanged with sticky=0.
  - shift=63 yields a single bit in[63] (logical) or all fill bits (arith).
- Simultaneous accept and emit in the same cycle with a full pipe is legal; occupancy stays 3.
- in_data/shift/arith are ignored when in_valid=0 or in_ready=0.
- Reset asserted mid-operation discards all in-flight beats immediately; no output is produced for them.
- busy = v1 | v2 | v3.

Test Plan:
- Logical shift, out_ready=1: in_data=0x8000_0000_0000_0001, shift=1, arith=0 -> exactly 3 cycles later out_data=0x4000_0000_0000_0000, out_sticky=1.
- Arithmetic extremes:
  - in_data=0x8000_0000_0000_0000, shift=63, arith=1 -> out_data=0xFFFF_FFFF_FFFF_FFFF, sticky=0.
  - Same with arith=0 -> out_data=0x0000_0000_0000_0001, sticky=0.
- Pass-through and mixed amounts: shift=0, in_data=0x0123_4567_89AB_CDEF -> identical output, sticky=0. shift=37, in_data=0xFFFF_FFFF_0000_0000, arith=0 -> out_data=0x0000_0000_07FF_FFFF, sticky=1.
- Backpressure: out_ready=0, drive 4 back-to-back valid beats A,B,C,D.
  - in_ready falls after the 3rd acceptance and D is held.
  - Raise out_ready -> A,B,C,D emerge on consecutive cycles, in order, with correct values.
  - out_data stays stable throughout the stall.
- Bubble collapse: accept one beat, hold out_ready=0 for 5 cycles -> beat sits in stage 3, in_ready stays 1 for two more acceptances, then falls.
- Reset mid-flight: with 3 beats in flight, pulse rst_n low for 1 cycle (asynchronous, off a clock edge) -> out_valid and busy drop to 0 immediately, no stale beat appears afterward, and in_ready=1.

Source files
------------

// File: rtl/barrel_shifter_right_pipe.sv
// 64-bit right barrel shifter, three registered stages with valid/ready flow
// control. Stage 1 shifts by 0..3, stage 2 by 0/4/8/12, stage 3 by 0/16/32/48.
// Each stage ORs the bits it discards into a sticky flag, and carries the fill
// bit (arith & msb) forward so later stages can sign-fill.
module barrel_shifter_right_pipe #(
    parameter int WIDTH = 64,
    parameter int SHW   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   shift,
    input  logic             arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sticky,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ONES = '1;

    // Stage registers
    logic             r1_valid, r2_valid, r3_valid;
    logic [WIDTH-1:0] r1_data, r2_data, r3_data;
    logic [3:0]       r1_shift;          // shift[5:2] still to apply
    logic [1:0]       r2_shift;          // shift[5:4] still to apply
    logic             r1_fill, r2_fill;
    logic             r1_sticky, r2_sticky, r3_sticky;

    // Per-stage advance: a stage may load when the stage ahead of it can take
    // its current contents (or it is empty). Chain is combinational from
    // out_ready, so in_ready has no skid buffer behind it.
    logic w_adv1, w_adv2, w_adv3;
    assign w_adv3 = ~r3_valid | out_ready;
    assign w_adv2 = ~r2_valid | w_adv3;
    assign w_adv1 = ~r1_valid | w_adv2;

    // Stage 1 datapath: shift by shift[1:0]
    logic [1:0]       w_s1_amt;
    logic             w_s1_fill;
    logic [WIDTH-1:0] w_s1_data;
    logic             w_s1_sticky;
    assign w_s1_amt    = shift[1:0];
    assign w_s1_fill   = arith & in_data[WIDTH-1];
    assign w_s1_data   = (in_data >> w_s1_amt) | ({WIDTH{w_s1_fill}} & ~(ONES >> w_s1_amt));
    assign w_s1_sticky = |(in_data & ~(ONES << w_s1_amt));

    // Stage 2 datapath: shift by 4 * r1_shift[1:0]
    logic [3:0]       w_s2_amt;
    logic [WIDTH-1:0] w_s2_data;
    logic             w_s2_sticky;
    assign w_s2_amt    = {r1_shift[1:0], 2'b00};
    assign w_s2_data   = (r1_data >> w_s2_amt) | ({WIDTH{r1_fill}} & ~(ONES >> w_s2_amt));
    assign w_s2_sticky = r1_sticky | (|(r1_data & ~(ONES << w_s2_amt)));

    // Stage 3 datapath: shift by 16 * r2_shift
    logic [5:0]       w_s3_amt;
    logic [WIDTH-1:0] w_s3_data;
    logic             w_s3_sticky;
    assign w_s3_amt    = {r2_shift, 4'b0000};
    assign w_s3_data   = (r2_data >> w_s3_amt) | ({WIDTH{r2_fill}} & ~(ONES >> w_s3_amt));
    assign w_s3_sticky = r2_sticky | (|(r2_data & ~(ONES << w_s3_amt)));

    // Stage 1 register: capture an input beat when stage 1 can advance
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data registers are reset too, so out_data reads 0 after
            // reset rather than whatever was in flight.
            r1_valid  <= 1'b0;
            r1_data   <= '0;
            r1_shift  <= '0;
            r1_fill   <= 1'b0;
            r1_sticky <= 1'b0;
        end else if (w_adv1) begin
            r1_valid <= in_valid;
            if (in_valid) begin
                r1_data   <= w_s1_data;
                r1_shift  <= shift[5:2];
                r1_fill   <= w_s1_fill;
                r1_sticky <= w_s1_sticky;
            end
        end
    end

    // Stage 2 register: take stage 1's beat when stage 2 can advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_valid  <= 1'b0;
            r2_data   <= '0;
            r2_shift  <= '0;
            r2_fill   <= 1'b0;
            r2_sticky <= 1'b0;
        end else if (w_adv2) begin
            r2_valid <= r1_valid;
            if (r1_valid) begin
                r2_data   <= w_s2_data;
                r2_shift  <= r1_shift[3:2];
                r2_fill   <= r1_fill;
                r2_sticky <= w_s2_sticky;
            end
        end
    end

    // Stage 3 register: output stage, holds steady while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r3_valid  <= 1'b0;
            r3_data   <= '0;
            r3_sticky <= 1'b0;
        end else if (w_adv3) begin
            r3_valid <= r2_valid;
            if (r2_valid) begin
                r3_data   <= w_s3_data;
                r3_sticky <= w_s3_sticky;
            end
        end
    end

    assign in_ready   = w_adv1;
    assign out_valid  = r3_valid;
    assign out_data   = r3_data;
    assign out_sticky = r3_sticky;
    assign busy       = r1_valid | r2_valid | r3_valid;

endmodule

// File: tb/tb_barrel_shifter_right_pipe.sv
// Directed testbench for barrel_shifter_right_pipe.
module tb_barrel_shifter_right_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [5:0]  shift;
    logic        arith;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_sticky;
    logic        busy;

    int checks = 0;
    int errors = 0;

    barrel_shifter_right_pipe #(.WIDTH(64), .SHW(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .shift      (shift),
        .arith      (arith),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sticky (out_sticky),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Push one beat into an empty pipe with out_ready=1 and report what was seen
    task automatic run_one(input logic [63:0] d, input logic [5:0] sh, input logic ar,
                           output logic rdy, output logic v_n1, output logic v_n2,
                           output logic v_n3, output logic [63:0] dat,
                           output logic stk, output logic busy_after);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; shift = sh; arith = ar; out_ready = 1'b1;
        rdy = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        v_n1 = out_valid;
        @(posedge clk); #1;
        v_n2 = out_valid;
        @(posedge clk); #1;
        v_n3 = out_valid; dat = out_data; stk = out_sticky;
        @(posedge clk); #1;
        busy_after = busy;
    endtask

    // Compare one run_one result against hand-computed expectations
    task automatic test_vector(input string name, input logic [63:0] d, input logic [5:0] sh,
                               input logic ar, input logic [63:0] exp_d, input logic exp_s);
        logic rdy, v1, v2, v3, stk, bz;
        logic [63:0] dat;
        run_one(d, sh, ar, rdy, v1, v2, v3, dat, stk, bz);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL %s in_ready: got %b want 1", name, rdy); end
        checks++;
        if ({v1, v2} !== 2'b00) begin errors++; $display("FAIL %s early out_valid: got %b want 00", name, {v1, v2}); end
        checks++;
        if (v3 !== 1'b1) begin errors++; $display("FAIL %s out_valid at N+3: got %b want 1", name, v3); end
        checks++;
        if (dat !== exp_d) begin errors++; $display("FAIL %s out_data: got %h want %h", name, dat, exp_d); end
        checks++;
        if (stk !== exp_s) begin errors++; $display("FAIL %s out_sticky: got %b want %b", name, stk, exp_s); end
        checks++;
        if (bz !== 1'b0) begin errors++; $display("FAIL %s busy after drain: got %b want 0", name, bz); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; shift = '0; arith = 1'b0; out_ready = 1'b0;
        #3;
        checks++;
        if ({out_valid, busy, in_ready, out_sticky} !== 4'b0010 || out_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_during: got v=%b busy=%b rdy=%b stk=%b data=%h want 0 0 1 0 0",
                     out_valid, busy, in_ready, out_sticky, out_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, busy, in_ready, out_sticky} !== 4'b0010 || out_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_after: got v=%b busy=%b rdy=%b stk=%b data=%h want 0 0 1 0 0",
                     out_valid, busy, in_ready, out_sticky, out_data);
        end
    endtask

    task automatic test_logical();
        test_vector("logical_sh1", 64'h8000_0000_0000_0001, 6'd1, 1'b0, 64'h4000_0000_0000_0000, 1'b1);
    endtask

    task automatic test_arith_extremes();
        test_vector("arith_sh63", 64'h8000_0000_0000_0000, 6'd63, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        test_vector("logic_sh63", 64'h8000_0000_0000_0000, 6'd63, 1'b0, 64'h0000_0000_0000_0001, 1'b0);
    endtask

    task automatic test_mixed();
        test_vector("pass_sh0", 64'h0123_4567_89AB_CDEF, 6'd0, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0);
        test_vector("sh37", 64'hFFFF_FFFF_0000_0000, 6'd37, 1'b0, 64'h0000_0000_07FF_FFFF, 1'b1);
        test_vector("arith_sh1_alt", 64'hAAAA_AAAA_AAAA_AAAA, 6'd1, 1'b1, 64'hD555_5555_5555_5555, 1'b0);
    endtask

    // Four back-to-back beats against a stalled consumer, then drain
    task automatic test_back_to_back();
        logic [63:0] vd [4];
        logic [5:0]  vs [4];
        logic        va [4];
        logic [63:0] ed [4];
        logic        es [4];
        vd[0] = 64'h0123_4567_89AB_CDEF; vs[0] = 6'd4;  va[0] = 1'b0; ed[0] = 64'h0012_3456_789A_BCDE; es[0] = 1'b1;
        vd[1] = 64'hF000_0000_0000_0000; vs[1] = 6'd8;  va[1] = 1'b1; ed[1] = 64'hFFF0_0000_0000_0000; es[1] = 1'b0;
        vd[2] = 64'h0000_0000_0000_00FF; vs[2] = 6'd16; va[2] = 1'b0; ed[2] = 64'h0000_0000_0000_0000; es[2] = 1'b1;
        vd[3] = 64'h8000_0000_0000_0000; vs[3] = 6'd2;  va[3] = 1'b1; ed[3] = 64'hE000_0000_0000_0000; es[3] = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = vd[i]; shift = vs[i]; arith = va[i];
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL bp accept %0d in_ready: got %b want 1", i, in_ready); end
            @(posedge clk);
        end
        // D is presented and must be held off while the pipe is full
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = vd[3]; shift = vs[3]; arith = va[3];
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp full cycle %0d in_ready: got %b want 0", c, in_ready); end
            checks++;
            if (out_valid !== 1'b1 || out_data !== ed[0] || out_sticky !== es[0]) begin
                errors++;
                $display("FAIL bp stall cycle %0d: got v=%b data=%h stk=%b want 1 %h %b",
                         c, out_valid, out_data, out_sticky, ed[0], es[0]);
            end
        end
        // Release: D goes in as A leaves, then A..D emerge on consecutive cycles
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp release in_ready: got %b want 1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== ed[i] || out_sticky !== es[i]) begin
                errors++;
                $display("FAIL bp drain beat %0d: got v=%b data=%h stk=%b want 1 %h %b",
                         i, out_valid, out_data, out_sticky, ed[i], es[i]);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL bp empty after drain: got v=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    // One beat settles into stage 3; two more are still accepted behind it
    task automatic test_bubble_collapse();
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = 64'h0000_0000_0000_0100; shift = 6'd8; arith = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'd1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bubble settled: got v=%b data=%h rdy=%b want 1 %h 1", out_valid, out_data, in_ready, 64'd1);
        end
        in_valid = 1'b1; in_data = 64'hAAAA_AAAA_AAAA_AAAA; shift = 6'd1; arith = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble second accept in_ready: got %b want 1", in_ready); end
        in_data = 64'h5555_5555_5555_5555; shift = 6'd63; arith = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bubble full in_ready: got %b want 0", in_ready); end
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_data !== 64'd1 || out_sticky !== 1'b0) begin
            errors++; $display("FAIL bubble beat0: got %h/%b want %h/0", out_data, out_sticky, 64'd1);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'hD555_5555_5555_5555 || out_sticky !== 1'b0) begin
            errors++; $display("FAIL bubble beat1: got v=%b %h/%b want 1 d555555555555555/0", out_valid, out_data, out_sticky);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'd0 || out_sticky !== 1'b1) begin
            errors++; $display("FAIL bubble beat2: got v=%b %h/%b want 1 0/1", out_valid, out_data, out_sticky);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL bubble drained busy: got %b want 0", busy); end
    endtask

    // Asynchronous reset with a full pipe discards everything
    task automatic test_reset_midflight();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 64'hFFFF_0000_FFFF_0000 + 64'(i); shift = 6'(i + 3); arith = 1'b1;
            @(posedge clk);
        end
        #3;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL midreset pre: got busy=%b v=%b want 1 1", busy, out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_data !== 64'd0) begin
            errors++;
            $display("FAIL midreset immediate: got v=%b busy=%b rdy=%b data=%h want 0 0 1 0", out_valid, busy, in_ready, out_data);
        end
        #9;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL midreset after cycle %0d: got v=%b busy=%b rdy=%b want 0 0 1", c, out_valid, busy, in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_logical();
        test_arith_extremes();
        test_mixed();
        test_back_to_back();
        test_bubble_collapse();
        test_reset_midflight();
        test_vector("after_reset", 64'h0123_4567_89AB_CDEF, 6'd12, 1'b0, 64'h0000_1234_5678_9ABC, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
